dk3_pocket_vid_out: RTL and testbench
=====================================

# dk3_pocket_vid_out

Video output adapter directly downstream of the Donkey Kong 3 core top level. It takes the core's 4-bit RGB, active-low syncs, blanking flags and pixel-phase signal, all in the 24 MHz domain. It produces the Analogue Pocket scaler video bus:
- 24-bit RGB, gated to zero outside the active area
- data enable
- single-pixel HS/VS pulses, with HS kept off the VS pixel
- a pixel strobe

It also measures active pixels per line and active lines per frame for bring-up and verification.

## Interface
Parameters:
- `HS_DEFER`, default 1: number of pixel strobes HS is pushed back when it coincides with VS (1–3).

Ports:
- `I_CLK_24M`  in  1: core clock, 24 MHz.
- `I_RESETn`  in  1: asynchronous, active-low reset.
- `I_PIX`  in  1: pixel phase from the core. Each rising edge marks one pixel.
- `I_R`, `I_G`, `I_B`  in  4 each: core colour.
- `I_HSYNCn`, `I_VSYNCn`  in  1 each: core syncs, active low.
- `I_HBLANK`, `I_VBLANK`  in  1 each: core blanking, active high.
- `O_PIX_CE`  out  1: one-clock strobe. Asserted on the same cycle the outputs update.
- `O_RGB`  out  24: {R8,G8,B8}.
- `O_DE`  out  1: data enable.
- `O_HS`, `O_VS`  out  1 each: active-high sync pulses, each lasting exactly one pixel period.
- `O_LINE_PIX`  out  9: active pixel count of the last completed line.
- `O_FRAME_LINES`  out  9: active line count of the last completed frame.

## Operation
- **Strobe.** `pix_q` is a flop holding `I_PIX` delayed one clock. `ce = I_PIX & ~pix_q`. All colour, sync and blank inputs are sampled only on `ce` cycles.
- **Output update.** On each `ce`, the registered outputs load and `O_PIX_CE` pulses on the following clock.
- **DE.** `de = ~I_HBLANK & ~I_VBLANK`.
- **Colour expansion.** Each 4-bit channel expands to 8 bits by nibble replication, {x,x}. 4'hF → 8'hFF; 4'h5 → 8'h55.
- **Colour gating.** `O_RGB` is 24'h0 whenever `O_DE` is 0.
- **Sync edge detect.** Per-strobe history registers `hs_q` and `vs_q` hold the last sampled syncs. A falling edge is detected when the previous sample was 1 and the current sample is 0.
- **VS.** A VS edge asserts `O_VS` for the current output pixel only.
- **HS, no conflict.** An HS edge asserts `O_HS` for the current output pixel.
- **HS, coincident with VS.** If a VS pulse is emitted on the same pixel, HS is loaded into a pending down-counter set to `HS_DEFER`. The counter decrements on each `ce`. `O_HS` asserts on the strobe where it reaches 0.
- **HS/VS mutual exclusion.** `O_HS` and `O_VS` are never both 1.
- **HS edge while pending.** The counter is not restarted; the new edge is dropped. A deferred HS landing on another VS strobe is deferred once more by the same rule.
- **Pixel counter (9-bit).** Increments on each `ce` with `de` = 1. On the first `ce` with `de` = 0 after `de` = 1:
  - the count latches into `O_LINE_PIX`;
  - the counter clears;
  - the 9-bit line counter increments.
  - The pixel counter saturates at 511.
- **Line counter (9-bit).** On a VS edge it latches into `O_FRAME_LINES` and clears. It saturates at 511.
- **DE ending on VS strobe.** If DE ends on the same strobe as a VS edge, the line increment is applied before the latch. The latched value includes that line.
- **Reset (asynchronous).** All outputs go to 0. `pix_q`, `hs_q` and `vs_q` go to 1, so no false edge occurs after release. Counters and the pending HS clear.
- **Mid-frame reset.** Reset mid-frame is legal. Statistics resume from the first full line and frame after release; the first partial values may be latched.

## Timing
- Output latency: 1 `I_CLK_24M` cycle after the `ce` cycle.
- Outputs hold their value between strobes, so each output pixel lasts the full pixel period.
- `O_PIX_CE` is high for exactly one clock per pixel.
- A strobe rate above `I_CLK_24M`/2 is not possible by construction.
- Statistics outputs update on the same clock as the corresponding pixel outputs.

## Structure
- Shared package `dk3_video_pkg`:
  - `RGB_IN_W` = 4;
  - `STAT_W` = 9;
  - function `expand4to8`;
  - constant `HS_DEFER_MAX` = 3.
- One sub-module, `dk3_vid_stats`:
  - inputs: clock, reset, `ce`, `de`, `vs_edge`;
  - outputs: `O_LINE_PIX`, `O_FRAME_LINES`.
- Strobe, sync and colour pipeline stay in the parent.

## Test plan
- **Reset values.** Hold `I_RESETn` = 0 with random inputs → all outputs 0. Release → no HS/VS pulse before the first real falling edge.
- **Colour and gating.** Pixel R=4'hF, G=4'h5, B=4'h0 with blanks low → `O_RGB` = 24'hFF5500 and `O_DE` = 1, 1 clock after the strobe. Same pixel with `I_HBLANK` = 1 → `O_RGB` = 0, `O_DE` = 0.
- **Frame statistics.** Drive 256 active pixels per line and 224 active lines → `O_LINE_PIX` = 256 after each line. `O_FRAME_LINES` = 224 after the next VS edge.
- **Coincident syncs.** HSYNCn and VSYNCn fall on the same strobe with `HS_DEFER` = 1 → `O_VS` on pixel n, `O_HS` on pixel n+1, never overlapping. Repeat with `HS_DEFER` = 3 → HS on n+3.
- **Strobe cadence.** `I_PIX` toggling every 2 clocks (6 MHz strobe) → exactly one `O_PIX_CE` per `I_PIX` rising edge. Sync pulse width = 4 clocks.
- **Mid-frame reset.** Assert `I_RESETn` for 3 clocks at line 100 → outputs 0 immediately. After release, the second completed frame reports `O_FRAME_LINES` = 224.

Source files
------------

// File: rtl/dk3_video_pkg.sv
// Shared constants and helpers for the DK3 video output path.
package dk3_video_pkg;

  localparam int RGB_IN_W     = 4;
  localparam int STAT_W       = 9;
  localparam int HS_DEFER_MAX = 3;
  localparam int DEFER_W      = $clog2(HS_DEFER_MAX + 1);

  // Nibble replication maps 0..F onto the full 0..FF range evenly.
  function automatic logic [2*RGB_IN_W-1:0] expand4to8(input logic [RGB_IN_W-1:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/dk3_vid_stats.sv
// Active pixels-per-line and lines-per-frame measurement, advanced on pixel strobes.
module dk3_vid_stats
  import dk3_video_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              de,
  input  logic              vs_edge,
  output logic [STAT_W-1:0] O_LINE_PIX,
  output logic [STAT_W-1:0] O_FRAME_LINES
);

  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] pix_cnt;
  logic [STAT_W-1:0] line_cnt;
  logic [STAT_W-1:0] line_next;
  logic              de_q;
  logic              line_end;

  // Line count including a line that ends on this strobe, so a VS on the
  // same strobe latches it.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    line_end  = ~de & de_q;
    line_next = line_cnt;
    if (line_end && line_cnt != STAT_MAX) line_next = line_cnt + STAT_W'(1);
  end

  // NOTE: all clocked state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt       <= '0;
      line_cnt      <= '0;
      de_q          <= 1'b0;
      O_LINE_PIX    <= '0;
      O_FRAME_LINES <= '0;
    end else if (ce) begin
      de_q <= de;
      if (de) begin
        if (pix_cnt != STAT_MAX) pix_cnt <= pix_cnt + STAT_W'(1);
      end else if (line_end) begin
        O_LINE_PIX <= pix_cnt;
        pix_cnt    <= '0;
      end
      if (vs_edge) begin
        O_FRAME_LINES <= line_next;
        line_cnt      <= '0;
      end else begin
        line_cnt <= line_next;
      end
    end
  end

endmodule

// File: rtl/dk3_pocket_vid_out.sv
// DK3 core video to Analogue Pocket scaler bus: strobe, colour expansion,
// single-pixel syncs with HS deferred off the VS pixel, plus line/frame stats.
module dk3_pocket_vid_out
  import dk3_video_pkg::*;
#(
  parameter int HS_DEFER = 1
) (
  input  logic                I_CLK_24M,
  input  logic                I_RESETn,
  input  logic                I_PIX,
  input  logic [RGB_IN_W-1:0] I_R,
  input  logic [RGB_IN_W-1:0] I_G,
  input  logic [RGB_IN_W-1:0] I_B,
  input  logic                I_HSYNCn,
  input  logic                I_VSYNCn,
  input  logic                I_HBLANK,
  input  logic                I_VBLANK,
  output logic                O_PIX_CE,
  output logic [23:0]         O_RGB,
  output logic                O_DE,
  output logic                O_HS,
  output logic                O_VS,
  output logic [STAT_W-1:0]   O_LINE_PIX,
  output logic [STAT_W-1:0]   O_FRAME_LINES
);

  localparam logic [DEFER_W-1:0] DEFER = DEFER_W'(HS_DEFER);

  logic               pix_q;
  logic               hs_q;
  logic               vs_q;
  logic               ce;
  logic               de;
  logic               hs_edge;
  logic               vs_edge;
  logic               hs_fire;
  logic               hs_out;
  logic [DEFER_W-1:0] hs_cnt;
  logic [DEFER_W-1:0] hs_cnt_nxt;

  always_comb begin
    ce      = I_PIX & ~pix_q;
    de      = ~I_HBLANK & ~I_VBLANK;
    hs_edge = hs_q & ~I_HSYNCn;
    vs_edge = vs_q & ~I_VSYNCn;
  end

  // hs_cnt == 0 means nothing pending; a pending HS fires as the count
  // reaches zero, and new edges are ignored while one is pending.
  always_comb begin
    hs_fire    = (hs_cnt != '0) ? (hs_cnt == DEFER_W'(1)) : hs_edge;
    hs_cnt_nxt = hs_cnt;
    hs_out     = 1'b0;
    if (hs_fire && vs_edge) begin
      hs_cnt_nxt = DEFER;
    end else if (hs_cnt != '0) begin
      hs_cnt_nxt = hs_cnt - DEFER_W'(1);
      hs_out     = hs_fire;
    end else begin
      hs_out = hs_fire;
    end
  end

  // Sync history resets high so a low sync at release is not a false edge.
  // NOTE: only control/pipeline flops exist here, so all of them take the async reset.
  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      pix_q    <= 1'b1;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      hs_cnt   <= '0;
      O_PIX_CE <= 1'b0;
      O_RGB    <= '0;
      O_DE     <= 1'b0;
      O_HS     <= 1'b0;
      O_VS     <= 1'b0;
    end else begin
      pix_q    <= I_PIX;
      O_PIX_CE <= ce;
      if (ce) begin
        hs_q   <= I_HSYNCn;
        vs_q   <= I_VSYNCn;
        hs_cnt <= hs_cnt_nxt;
        O_RGB  <= de ? {expand4to8(I_R), expand4to8(I_G), expand4to8(I_B)} : 24'h0;
        O_DE   <= de;
        O_HS   <= hs_out;
        O_VS   <= vs_edge;
      end
    end
  end

  dk3_vid_stats u_stats (
    .clk           (I_CLK_24M),
    .rst_n         (I_RESETn),
    .ce            (ce),
    .de            (de),
    .vs_edge       (vs_edge),
    .O_LINE_PIX    (O_LINE_PIX),
    .O_FRAME_LINES (O_FRAME_LINES)
  );

endmodule

// File: tb/tb_dk3_pocket_vid_out.sv
// Scoreboard bench for dk3_pocket_vid_out: two instances (HS_DEFER 1 and 3) share stimulus.
module tb_dk3_pocket_vid_out;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic [8:0]  line_pix;
    logic [8:0]  frame_lines;
  } vid_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pix = 1'b0;
  logic [3:0] r = '0, g = '0, b = '0;
  logic       hsn = 1'b1, vsn = 1'b1, hb = 1'b1, vb = 1'b1;

  logic        ce0, de0, hs0, vs0, ce1, de1, hs1, vs1;
  logic [23:0] rgb0, rgb1;
  logic [8:0]  lp0, fl0, lp1, fl1;

  always #5 clk = ~clk;

  dk3_pocket_vid_out #(.HS_DEFER(1)) dut0 (
    .I_CLK_24M(clk), .I_RESETn(rst_n), .I_PIX(pix),
    .I_R(r), .I_G(g), .I_B(b),
    .I_HSYNCn(hsn), .I_VSYNCn(vsn), .I_HBLANK(hb), .I_VBLANK(vb),
    .O_PIX_CE(ce0), .O_RGB(rgb0), .O_DE(de0), .O_HS(hs0), .O_VS(vs0),
    .O_LINE_PIX(lp0), .O_FRAME_LINES(fl0)
  );

  dk3_pocket_vid_out #(.HS_DEFER(3)) dut1 (
    .I_CLK_24M(clk), .I_RESETn(rst_n), .I_PIX(pix),
    .I_R(r), .I_G(g), .I_B(b),
    .I_HSYNCn(hsn), .I_VSYNCn(vsn), .I_HBLANK(hb), .I_VBLANK(vb),
    .O_PIX_CE(ce1), .O_RGB(rgb1), .O_DE(de1), .O_HS(hs1), .O_VS(vs1),
    .O_LINE_PIX(lp1), .O_FRAME_LINES(fl1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  vid_t q0[$];
  vid_t q1[$];
  bit   m_hs_q, m_vs_q, m_de_q;
  int   m_n, m_run, m_lines;
  int   m_lp, m_fl;
  bit   m_pend[2];
  int   m_due[2];
  int   defer_of[2] = '{1, 3};

  task automatic model_reset();
    m_hs_q = 1; m_vs_q = 1; m_de_q = 0;
    m_n = 0; m_run = 0; m_lines = 0; m_lp = 0; m_fl = 0;
    m_pend = '{0, 0};
    m_due  = '{0, 0};
    q0.delete();
    q1.delete();
  endtask

  task automatic model_pixel();
    bit   de, vs_e, hs_e;
    vid_t e;
    de   = !hb && !vb;
    vs_e = m_vs_q && !vsn;
    hs_e = m_hs_q && !hsn;
    if (de) m_run = (m_run < 511) ? m_run + 1 : 511;
    else if (m_de_q) begin
      m_lp    = m_run;
      m_run   = 0;
      m_lines = (m_lines < 511) ? m_lines + 1 : 511;
    end
    if (vs_e) begin
      m_fl    = m_lines;
      m_lines = 0;
    end
    for (int d = 0; d < 2; d++) begin
      e.rgb         = de ? {8'(r * 17), 8'(g * 17), 8'(b * 17)} : 24'h0;
      e.de          = de;
      e.vs          = vs_e;
      e.hs          = 1'b0;
      e.line_pix    = 9'(m_lp);
      e.frame_lines = 9'(m_fl);
      if (m_pend[d]) begin
        if (m_n == m_due[d]) begin
          if (vs_e) m_due[d] += defer_of[d];
          else begin
            e.hs      = 1'b1;
            m_pend[d] = 0;
          end
        end
      end else if (hs_e) begin
        if (vs_e) begin
          m_pend[d] = 1;
          m_due[d]  = m_n + defer_of[d];
        end else e.hs = 1'b1;
      end
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    m_de_q = de; m_hs_q = hsn; m_vs_q = vsn;
    m_n++;
  endtask

  // ---------------- stimulus helpers ----------------
  int ph = 1, pl = 1;
  bit rand_period = 0;
  int issued = 0;

  task automatic px(input logic [3:0] rr, gg, bb, input logic hs_n, vs_n, hbl, vbl);
    int h, l;
    h = rand_period ? int'($urandom_range(1, 3)) : ph;
    l = rand_period ? int'($urandom_range(1, 2)) : pl;
    r = rr; g = gg; b = bb; hsn = hs_n; vsn = vs_n; hb = hbl; vb = vbl;
    pix = 1'b1;
    model_pixel();
    issued++;
    repeat (h) @(negedge clk);
    pix = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic vs_pixels();
    px(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    px(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_dut0"}, {18'd0, ce0, rgb0, de0, hs0, vs0, lp0, fl0}, 64'd0);
    check({tag, "_dut1"}, {18'd0, ce1, rgb1, de1, hs1, vs1, lp1, fl1}, 64'd0);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check_outs_zero("midreset");
    model_reset();
    repeat (3) @(negedge clk);
    pix   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_body(input int reset_line);
    for (int ln = 0; ln < 2; ln++)
      for (int i = 0; i < 6; i++) px(4'h0, 4'h0, 4'h0, i != 4, 1'b1, 1'b1, 1'b1);
    for (int ln = 0; ln < 224; ln++) begin
      if (ln == reset_line) mid_reset();
      for (int i = 0; i < 4; i++)
        px(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) px(4'h0, 4'h0, 4'h0, i != 0, 1'b1, 1'b1, 1'b0);
    end
  endtask

  // ---------------- monitor ----------------
  vid_t e0, e1;
  int   ce_seen = 0, pop_n0 = 0, pop_n1 = 0;
  int   vs_idx0 = -1, hs_idx0 = -1, vs_idx1 = -1, hs_idx1 = -1;
  int   vs_run = 0, hs_run = 0, vs_w = 0, hs_w = 0;

  always @(negedge clk) begin
    if (rst_n && ce0) begin
      ce_seen++;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ce0: got pix_ce with empty queue (t=%0t)", $time);
      end else begin
        e0 = q0.pop_front();
        check("pix_dut0", {19'd0, rgb0, de0, hs0, vs0, lp0, fl0}, {19'd0, e0});
        if (vs0) vs_idx0 = pop_n0;
        if (hs0) hs_idx0 = pop_n0;
        pop_n0++;
      end
    end
    if (rst_n && ce1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ce1: got pix_ce with empty queue (t=%0t)", $time);
      end else begin
        e1 = q1.pop_front();
        check("pix_dut1", {19'd0, rgb1, de1, hs1, vs1, lp1, fl1}, {19'd0, e1});
        if (vs1) vs_idx1 = pop_n1;
        if (hs1) hs_idx1 = pop_n1;
        pop_n1++;
      end
    end
    if (vs0) vs_run++;
    else if (vs_run != 0) begin vs_w = vs_run; vs_run = 0; end
    if (hs0) hs_run++;
    else if (hs_run != 0) begin hs_w = hs_run; hs_run = 0; end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base0, base1;
    model_reset();
    #3 rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_outs_zero("reset");
      {r, g, b} = 12'($urandom);
      hsn = 1'($urandom); vsn = 1'($urandom);
      hb  = 1'($urandom); vb  = 1'($urandom);
      pix = 1'($urandom);
    end
    pix = 1'b0; hsn = 1'b1; vsn = 1'b1; hb = 1'b1; vb = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // No sync pulses after release, then colour expansion and gating.
    for (int i = 0; i < 4; i++) px(4'h3, 4'h3, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1);
    px(4'hF, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rgb_ff5500", 64'(rgb0), 64'h00FF5500);
    check("de_active", 64'(de0), 64'd1);
    px(4'hF, 4'h5, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rgb_gated", 64'(rgb0), 64'd0);
    check("de_hblank", 64'(de0), 64'd0);

    // Coincident syncs at a 4-clock pixel period.
    ph = 2; pl = 2;
    base0 = pop_n0; base1 = pop_n1;
    for (int i = 0; i < 3; i++) px(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) px(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) px(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("vs_pixel_d1", 64'(vs_idx0), 64'(base0 + 3));
    check("hs_pixel_d1", 64'(hs_idx0), 64'(base0 + 4));
    check("vs_pixel_d3", 64'(vs_idx1), 64'(base1 + 3));
    check("hs_pixel_d3", 64'(hs_idx1), 64'(base1 + 6));
    check("vs_width_clks", 64'(vs_w), 64'd4);
    check("hs_width_clks", 64'(hs_w), 64'd4);
    check("cadence_4clk", 64'(ce_seen), 64'(issued));

    // 256-pixel lines, then pixel-counter saturation.
    ph = 1; pl = 1;
    for (int ln = 0; ln < 3; ln++) begin
      for (int i = 0; i < 256; i++)
        px(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) px(4'h0, 4'h0, 4'h0, i != 2, 1'b1, 1'b1, 1'b0);
      check("line_pix_256", 64'(lp0), 64'd256);
    end
    for (int i = 0; i < 520; i++) px(4'h1, 4'h2, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
    px(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("line_pix_sat", 64'(lp0), 64'd511);

    // Line-counter saturation.
    vs_pixels();
    for (int i = 0; i < 515; i++) begin
      px(4'h7, 4'h7, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0);
      px(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    vs_pixels();
    check("frame_lines_sat", 64'(fl0), 64'd511);

    // Full 224-line frames, with a mid-frame reset on line 100.
    rand_period = 1;
    vs_pixels();
    frame_body(-1);
    vs_pixels();
    check("frame_lines_224_d1", 64'(fl0), 64'd224);
    check("frame_lines_224_d3", 64'(fl1), 64'd224);
    frame_body(100);
    vs_pixels();
    frame_body(-1);
    vs_pixels();
    check("frame_after_reset_d1", 64'(fl0), 64'd224);
    check("frame_after_reset_d3", 64'(fl1), 64'd224);

    // Random traffic with frequent sync toggling.
    for (int i = 0; i < 1500; i++)
      px(4'($urandom), 4'($urandom), 4'($urandom),
         $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
         $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);

    repeat (4) @(negedge clk);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("cadence_total", 64'(ce_seen), 64'(issued));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
